// File: rtl/stopwatch_bcd_ctr.sv
// Multi-digit BCD up/down stopwatch counter with prescaled tick, start/stop, lap hold and preset.
// Define STOPWATCH_SATURATE_EN to saturate at the range limits instead of wrapping.
module stopwatch_bcd_ctr #(
  parameter int unsigned CLK_DIV    = 5000000,
  parameter int unsigned DIV_W      = 23,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    CLK_5MHz,
  input  logic                    reset,
  input  logic                    up_dn,
  input  logic                    start_stop,
  input  logic                    lap,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic [4*NUM_DIGITS-1:0] display,
  output logic                    running,
  output logic                    tick,
  output logic                    terminal
);

  localparam int unsigned W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {StStop, StRun, StLap} state_e;

  state_e           state_q;
  logic [DIV_W-1:0] pre_q;
  logic [W-1:0]     count_q;
  logic [W-1:0]     lap_q;
  logic             hold_q;
  logic             ss_prev_q;
  logic             lap_prev_q;

  logic             ss_rise;
  logic             lap_rise;
  logic             step_en;
  logic             wrap;
  logic [W-1:0]     step_val;
  logic [W-1:0]     load_clamped;
  logic [3:0]       digit;
  logic             carry;

  assign ss_rise  = start_stop & ~ss_prev_q;
  assign lap_rise = lap & ~lap_prev_q;
  assign running  = (state_q != StStop);
  assign tick     = ~reset & running & (pre_q == DIV_W'(CLK_DIV - 1));
  assign step_en  = tick & ~clear & ~load;
  assign terminal = step_en & wrap;
  assign count    = count_q;
  assign display  = hold_q ? lap_q : count_q;

  // Ripple BCD step; carry doubles as the borrow when counting down.
  always_comb begin
    step_val = count_q;
    carry    = 1'b1;
    digit    = 4'd0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      digit = count_q[4*i +: 4];
      if (carry) begin
        if (up_dn) begin
          if (digit == 4'd9) begin
            digit = 4'd0;
          end else begin
            digit = digit + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            digit = 4'd9;
          end else begin
            digit = digit - 4'd1;
            carry = 1'b0;
          end
        end
      end
      step_val[4*i +: 4] = digit;
    end
    wrap = carry;
  end

  always_comb begin
    load_clamped = load_val;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_clamped[4*i +: 4] = 4'd9;
    end
  end

  always_ff @(posedge CLK_5MHz) begin
    if (reset) begin
      state_q    <= StStop;
      pre_q      <= '0;
      count_q    <= '0;
      lap_q      <= '0;
      hold_q     <= 1'b0;
      ss_prev_q  <= 1'b0;
      lap_prev_q <= 1'b0;
    end else begin
      ss_prev_q  <= start_stop;
      lap_prev_q <= lap;

      if (clear) begin
        count_q <= '0;
      end else if (load) begin
        count_q <= load_clamped;
      end else if (step_en) begin
`ifdef STOPWATCH_SATURATE_EN
        if (!wrap) count_q <= step_val;
`else
        count_q <= step_val;
`endif
      end

      // Prescaler holds while stopped so a pause keeps the partial period.
      if (clear || load) begin
        pre_q <= '0;
      end else if (running) begin
        pre_q <= tick ? '0 : pre_q + DIV_W'(1);
      end

      case (state_q)
        StStop: begin
          if (ss_rise) begin
            state_q <= hold_q ? StLap : StRun;
          end else if (lap_rise && hold_q) begin
            hold_q <= 1'b0;
          end
        end
        StRun: begin
          if (ss_rise) begin
            state_q <= StStop;
          end else if (lap_rise) begin
            state_q <= StLap;
            hold_q  <= 1'b1;
            lap_q   <= count_q;
          end
        end
        StLap: begin
          if (ss_rise) begin
            state_q <= StStop;
          end else if (lap_rise) begin
            state_q <= StRun;
            hold_q  <= 1'b0;
          end
        end
        default: state_q <= StStop;
      endcase

`ifdef STOPWATCH_SATURATE_EN
      if (terminal) state_q <= StStop;
`endif
    end
  end

endmodule
